// File: rtl/dm_mem_lat.sv
// dm_mem_lat: latency-configurable line memory with valid/ready request and response channels
module dm_mem_lat #(
    parameter int          ADDR_W    = 32,
    parameter int          LINE_W    = 128,
    parameter int          DEPTH     = 256,
    parameter int          READ_LAT  = 3,
    parameter int          WRITE_LAT = 2,
    parameter logic [31:0] INIT_SEED = 32'hDEAD_BEEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_rw,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [LINE_W-1:0]   req_wdata,
    input  logic [LINE_W/8-1:0] req_be,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [LINE_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                rsp_wr
);
    localparam int          BYTES   = LINE_W / 8;
    localparam int          WORDS   = LINE_W / 32;
    localparam int          OFFS    = $clog2(BYTES);
    localparam int          IW      = ADDR_W - OFFS;
    localparam int          AW      = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam logic [63:0] DEPTH64 = 64'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state, state_nx;
    logic [3:0]        cnt, cnt_nx, lat;
    logic              live;
    logic [DEPTH-1:0]  written;
    logic [LINE_W-1:0] mem [DEPTH];
    logic [LINE_W-1:0] rdata_q, pattern, base, merged, cap_data;
    logic              err_q, wr_q;
    logic [IW-1:0]     idx;
    logic [AW-1:0]     ai;
    logic              in_range, accept, wr_commit;
    logic              addr_unused;

    assign idx         = req_addr[ADDR_W-1:OFFS];
    assign addr_unused = ^req_addr[OFFS-1:0];
    assign ai          = idx[AW-1:0];
    assign in_range    = {{(64-IW){1'b0}}, idx} < DEPTH64;
    assign req_ready   = live && state == IDLE;
    assign accept      = req_valid && req_ready;
    assign wr_commit   = accept && req_rw && in_range && |req_be;
    assign lat         = req_rw ? 4'(WRITE_LAT) : 4'(READ_LAT);
    assign pattern     = {WORDS{INIT_SEED ^ 32'(idx)}};
    assign base        = written[ai] ? mem[ai] : pattern;
    assign cap_data    = (!req_rw && in_range) ? base : '0;
    assign rsp_valid   = state == RESP;
    assign rsp_rdata   = rsp_valid ? rdata_q : '0;
    assign rsp_err     = rsp_valid && err_q;
    assign rsp_wr      = rsp_valid && wr_q;

    // Byte-wise merge of write data over the current (or pattern) line contents
    always_comb begin
        merged = base;
        for (int b = 0; b < BYTES; b++)
            merged[b*8 +: 8] = req_be[b] ? req_wdata[b*8 +: 8] : base[b*8 +: 8];
    end

    // Array storage is deliberately not reset; validity lives in the written bits
    always_ff @(posedge clk) begin
        if (wr_commit)
            mem[ai] <= merged;
    end

    // Per-line written bits, cleared by reset to invalidate every line at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            written <= '0;
        else if (wr_commit)
            written[ai] <= 1'b1;
    end

    // State, latency counter, post-reset ready enable and captured response fields
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            live    <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            live  <= 1'b1;
            if (accept) begin
                rdata_q <= cap_data;
                err_q   <= !in_range;
                wr_q    <= req_rw;
            end
        end
    end

    // Next state: wait LAT edges from acceptance, then hold the response until consumed
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: if (accept) begin
                state_nx = lat == 4'd1 ? RESP : WAIT;
                cnt_nx   = lat - 4'd1;
            end
            WAIT: begin
                cnt_nx = cnt - 4'd1;
                if (cnt == 4'd1) state_nx = RESP;
            end
            RESP: if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_dm_mem_lat.sv
// tb_dm_mem_lat: directed tests of latency, data, error and back-pressure behaviour
module tb_dm_mem_lat;
    logic         clk = 0;
    logic         rst_n = 0;
    logic         req_valid = 0, req_ready, req_rw = 0;
    logic [31:0]  req_addr = '0;
    logic [127:0] req_wdata = '0;
    logic [15:0]  req_be = '0;
    logic         rsp_valid, rsp_ready = 0;
    logic [127:0] rsp_rdata;
    logic         rsp_err, rsp_wr;
    int           checks = 0, errors = 0;

    localparam logic [127:0] D = 128'h00112233445566778899AABBCCDDEEFF;

    dm_mem_lat dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_wr(rsp_wr)
    );

    always #5 clk = ~clk;

    task automatic issue(input logic rw, input logic [31:0] addr, input logic [127:0] wd,
                         input logic [15:0] be, output int lat, output logic [127:0] rd,
                         output logic err, output logic wr);
        int n = 0;
        while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
        req_valid = 1; req_rw = rw; req_addr = addr; req_wdata = wd; req_be = be;
        @(posedge clk); #1;
        req_valid = 0;
        lat = 1;
        while (!rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        rd = rsp_rdata; err = rsp_err; wr = rsp_wr;
    endtask

    task automatic consume;
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;
    endtask

    task automatic test_reset;
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got=%b exp=0", req_ready); end
        checks++; if ({rsp_valid, rsp_err, rsp_wr} !== 3'b000) begin errors++; $display("FAIL reset_rsp_flags got=%b exp=000", {rsp_valid, rsp_err, rsp_wr}); end
        checks++; if (rsp_rdata !== '0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", rsp_rdata); end
        rst_n = 1;
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL release_ready_before_edge got=%b exp=0", req_ready); end
        @(posedge clk); #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL release_ready_after_edge got=%b exp=1", req_ready); end
    endtask

    task automatic test_read_pattern;
        int lat; logic [127:0] rd; logic err, wr;
        issue(1'b0, 32'h50, '0, 16'hFFFF, lat, rd, err, wr);
        checks++; if (lat !== 3) begin errors++; $display("FAIL read_latency got=%0d exp=3", lat); end
        checks++; if (rd !== {4{32'hDEADBEEA}}) begin errors++; $display("FAIL read_pattern got=%h exp=%h", rd, {4{32'hDEADBEEA}}); end
        checks++; if ({err, wr} !== 2'b00) begin errors++; $display("FAIL read_flags got=%b exp=00", {err, wr}); end
        consume();
        checks++; if ({rsp_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL read_after_hs got=%b exp=01", {rsp_valid, req_ready}); end
        checks++; if (rsp_rdata !== '0) begin errors++; $display("FAIL rdata_cleared got=%h exp=0", rsp_rdata); end
    endtask

    task automatic test_write_read;
        int lat; logic [127:0] rd; logic err, wr;
        issue(1'b1, 32'h100, D, 16'hFFFF, lat, rd, err, wr);
        checks++; if (lat !== 2) begin errors++; $display("FAIL write_latency got=%0d exp=2", lat); end
        checks++; if ({err, wr} !== 2'b01) begin errors++; $display("FAIL write_flags got=%b exp=01", {err, wr}); end
        checks++; if (rd !== '0) begin errors++; $display("FAIL write_rdata got=%h exp=0", rd); end
        consume();
        issue(1'b0, 32'h10C, '0, '0, lat, rd, err, wr);
        checks++; if (rd !== D) begin errors++; $display("FAIL raw_data got=%h exp=%h", rd, D); end
        consume();
    endtask

    task automatic test_byte_enables;
        int lat; logic [127:0] rd; logic err, wr;
        issue(1'b1, 32'h20, {96'hFFFFFFFF_FFFFFFFF_FFFFFFFF, 32'h12345678}, 16'h000F, lat, rd, err, wr);
        consume();
        issue(1'b0, 32'h20, '0, '0, lat, rd, err, wr);
        checks++; if (rd !== {{3{32'hDEADBEED}}, 32'h12345678}) begin errors++; $display("FAIL partial_unwritten got=%h exp=%h", rd, {{3{32'hDEADBEED}}, 32'h12345678}); end
        consume();
        issue(1'b1, 32'h100, 128'hAA, 16'h0001, lat, rd, err, wr);
        consume();
        issue(1'b0, 32'h100, '0, '0, lat, rd, err, wr);
        checks++; if (rd !== 128'h00112233445566778899AABBCCDDEEAA) begin errors++; $display("FAIL partial_written got=%h exp=%h", rd, 128'h00112233445566778899AABBCCDDEEAA); end
        consume();
        issue(1'b1, 32'h70, D, 16'h0000, lat, rd, err, wr);
        checks++; if ({lat == 2, err, wr} !== 3'b101) begin errors++; $display("FAIL zero_be_rsp got=%b exp=101", {lat == 2, err, wr}); end
        consume();
        issue(1'b0, 32'h70, '0, '0, lat, rd, err, wr);
        checks++; if (rd !== {4{32'hDEADBEE8}}) begin errors++; $display("FAIL zero_be_data got=%h exp=%h", rd, {4{32'hDEADBEE8}}); end
        consume();
    endtask

    task automatic test_out_of_range;
        int lat; logic [127:0] rd; logic err, wr;
        issue(1'b0, 32'h1000, '0, '0, lat, rd, err, wr);
        checks++; if ({err, wr} !== 2'b10) begin errors++; $display("FAIL oor_read_flags got=%b exp=10", {err, wr}); end
        checks++; if (rd !== '0) begin errors++; $display("FAIL oor_read_rdata got=%h exp=0", rd); end
        consume();
        issue(1'b1, 32'h1000, D, 16'hFFFF, lat, rd, err, wr);
        checks++; if ({err, wr} !== 2'b11) begin errors++; $display("FAIL oor_write_flags got=%b exp=11", {err, wr}); end
        consume();
        issue(1'b0, 32'h0, '0, '0, lat, rd, err, wr);
        checks++; if (rd !== {4{32'hDEADBEEF}}) begin errors++; $display("FAIL index0_pattern got=%h exp=%h", rd, {4{32'hDEADBEEF}}); end
        consume();
        issue(1'b0, 32'hFF0, '0, '0, lat, rd, err, wr);
        checks++; if ({err, rd} !== {1'b0, {4{32'hDEADBE10}}}) begin errors++; $display("FAIL last_index got=%b/%h exp=0/%h", err, rd, {4{32'hDEADBE10}}); end
        consume();
    endtask

    task automatic test_backpressure;
        int lat; logic [127:0] rd; logic err, wr; int bad = 0;
        issue(1'b0, 32'h20, '0, '0, lat, rd, err, wr);
        repeat (10) begin
            @(posedge clk); #1;
            if (!rsp_valid || req_ready || rsp_rdata !== {{3{32'hDEADBEED}}, 32'h12345678}) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL backpressure_stable got=%0d unstable cycles exp=0", bad); end
        consume();
        checks++; if ({rsp_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL backpressure_release got=%b exp=01", {rsp_valid, req_ready}); end
    endtask

    task automatic test_reset_mid;
        int lat; logic [127:0] rd; logic err, wr; int seen = 0;
        issue(1'b1, 32'h30, D, 16'hFFFF, lat, rd, err, wr);
        consume();
        req_valid = 1; req_rw = 0; req_addr = 32'h30;
        @(posedge clk); #1;
        req_valid = 0;
        rst_n = 0;
        repeat (4) begin @(posedge clk); #1; if (rsp_valid) seen++; end
        rst_n = 1;
        repeat (4) begin @(posedge clk); #1; if (rsp_valid) seen++; end
        checks++; if (seen !== 0) begin errors++; $display("FAIL reset_drop got=%0d rsp cycles exp=0", seen); end
        issue(1'b0, 32'h30, '0, '0, lat, rd, err, wr);
        checks++; if (rd !== {4{32'hDEADBEEC}}) begin errors++; $display("FAIL reset_invalidate got=%h exp=%h", rd, {4{32'hDEADBEEC}}); end
        consume();
    endtask

    initial begin
        test_reset();
        test_read_pattern();
        test_write_read();
        test_byte_enables();
        test_out_of_range();
        test_backpressure();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dm_mem_lat.md
Name: dm_mem_lat

Overview:
- Parametrised, latency-configurable backing memory for the direct-mapped cache. Successor to the single-cycle model.
- Sits between the cache controller's memory port and the testbench.
- Adds a valid/ready handshake on both request and response, per-byte write enables, programmable read and write latency, and an error response for out-of-range addresses.
- Unwritten lines return a deterministic pattern instead of random data.
- Single outstanding request.

Parameters:
- ADDR_W, 32: request byte-address width.
- LINE_W, 128: line width in bits; a multiple of 32 and a power of two.
- DEPTH, 256: number of lines stored.
- READ_LAT, 3: cycles from request acceptance to rsp_valid for reads; range 1..15.
- WRITE_LAT, 2: the same for writes; range 1..15.
- INIT_SEED, 32'hDEAD_BEEF: seed for the unwritten-line pattern.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_rw  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  byte address
- req_wdata  in  LINE_W  write line data
- req_be  in  LINE_W/8  byte enables; ignored for reads
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  LINE_W  read data; zero for write responses
- rsp_err  out  1  out-of-range address
- rsp_wr  out  1  response belongs to a write

Behaviour:
- Reset (rst_n low, asynchronous):
  - FSM goes to IDLE; the latency counter is cleared.
  - All per-line written bits are cleared. The array contents are not reset.
  - Output reset values: req_ready=0 while rst_n is low, then 1 from the first clk edge after release. rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_wr=0.
  - Reset mid-operation drops the in-flight request. No response is issued, and any write already committed is invalidated along with all other lines.
- Indexing:
  - OFFS = log2(LINE_W/8); index = req_addr >> OFFS. The low OFFS bits are ignored.
  - index >= DEPTH means out of range.
- Accept: a request is accepted on a rising edge where req_valid && req_ready. req_ready=1 only in IDLE.
- At the accept edge:
  - Write, in range: for each byte b with req_be[b]=1, store req_wdata byte b. Bytes with req_be[b]=0 keep their old value; if the line is unwritten, they take the pattern byte. Then set the line's written bit.
  - Write with req_be all zero: no data change and the written bit is unchanged. A normal response is still returned.
  - Read, in range: capture the stored line if its written bit is set. Otherwise capture the pattern: every 32-bit word = INIT_SEED ^ zero-extended index.
  - Out of range: no array access. Captured data = 0 and the error flag is set.
- FSM states IDLE, WAIT, RESP:
  - IDLE -> RESP if the selected latency LAT == 1; otherwise IDLE -> WAIT with counter = LAT-1.
  - WAIT: decrement the counter each cycle; go to RESP when the counter reaches 1.
  - rsp_valid is first high LAT cycles after the accept edge.
  - RESP: rsp_valid=1 and the captured outputs are held stable. Go to IDLE on the edge where rsp_ready=1.
  - req_ready rises the cycle after the response handshake, so there is no back-to-back accept in the same cycle.
- Back-pressure: rsp_ready held low keeps RESP and all rsp_* outputs stable indefinitely.
- Ordering: single outstanding, so read-after-write to the same line always returns the written data.
- rsp_rdata returns to 0 on leaving RESP.

Test Plan:
- Read 0x50 (index 5) after reset, never written, rsp_ready=1 -> rsp_valid exactly 3 cycles after accept; rsp_rdata = {4{32'hDEADBEEA}}; rsp_err=0, rsp_wr=0.
- Write 0x100 with data 128'h0011..EEFF and be=16'hFFFF, then read 0x10C -> write response after 2 cycles with rsp_wr=1 and rdata=0; the read returns 128'h0011..EEFF.
- Write to unwritten 0x20 (index 2) with be=16'h000F and wdata low word 32'h12345678 -> a later read returns {3{32'hDEADBEED}, 32'h12345678}.
- Read 0x1000 (index 256, DEPTH=256) -> rsp_err=1, rsp_rdata=0; array unchanged (a read of index 0 still returns the pattern).
- Hold rsp_ready=0 for 10 cycles during a read response -> rsp_valid and rsp_rdata stable and req_ready=0 throughout; after rsp_ready pulses, req_ready=1 on the next cycle.
- Write 0x30, then assert rst_n=0 while a read of 0x30 is in WAIT -> no rsp_valid; after release, a read of 0x30 returns the pattern {4{32'hDEADBEEC}}.
